// File: rtl/snake_pkg.sv
// Shared constants and types for the key command encoder.
package snake_pkg;

  localparam int unsigned NUM_KEYS = 6;
  localparam int unsigned CODE_W   = 3;

  // Command codes equal the key index on key_db.
  localparam logic [CODE_W-1:0] CMD_UP    = 3'd0;
  localparam logic [CODE_W-1:0] CMD_DOWN  = 3'd1;
  localparam logic [CODE_W-1:0] CMD_LEFT  = 3'd2;
  localparam logic [CODE_W-1:0] CMD_RIGHT = 3'd3;
  localparam logic [CODE_W-1:0] CMD_START = 3'd4;
  localparam logic [CODE_W-1:0] CMD_CLEAR = 3'd5;

  // One queued command: auto-repeat flag plus key code.
  typedef struct packed {
    logic              rpt;
    logic [CODE_W-1:0] code;
  } cmd_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with first-word fall-through head; DEPTH must be a power of two.
module cmd_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full_c,
  output logic              valid_c,
  output logic [DATA_W-1:0] head_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_c, do_pop_c;

  // Status decode and pointer/count update; push while full only with a pop.
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    valid_c   = (count_q != '0);
    do_pop_c  = pop & valid_c;
    do_push_c = push & (~full_c | do_pop_c);
    wr_ptr_d  = do_push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push_c && !do_pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
    head_c = valid_c ? mem_q[rd_ptr_q] : '0;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/key_cmd_encoder.sv
// Turns debounced active-low key presses into queued commands.
// Optional auto-repeat of direction keys is built when KEY_REPEAT_EN is defined.
module key_cmd_encoder
  import snake_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       pixel_clk,
  input  logic       sys_rst,
  input  logic [5:0] key_db,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_code,
  output logic       cmd_rpt
);

  logic [NUM_KEYS-1:0] key_prev_q, key_prev_d;
  logic                first_q, first_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] pending_rpt_q, pending_rpt_d;
  logic [NUM_KEYS-1:0] press_c;
  logic [NUM_KEYS-1:0] rpt_evt_c;
  logic [CODE_W-1:0]   sel_c;
  logic                sel_any_c;
  logic                push_c, pop_c;
  logic                fifo_full_c, fifo_valid_c;
  cmd_t                push_cmd_c, head_c;

  // Edge detect; the first cycle after reset only resamples so held keys are ignored.
  always_comb begin
    key_prev_d = key_db;
    first_d    = 1'b0;
    press_c    = first_q ? '0 : (key_prev_q & ~key_db);
  end

  // Key history registers.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      key_prev_q <= '1;
      first_q    <= 1'b1;
    end else begin
      key_prev_q <= key_prev_d;
      first_q    <= first_d;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  rpt_state_e        state_q, state_d;
  logic [CODE_W-1:0] rpt_key_q, rpt_key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_press_c;
  logic [CODE_W-1:0] dir_idx_c;

  // Repeat FSM: new direction press restarts, release wins over expiry.
  always_comb begin
    state_d     = state_q;
    rpt_key_d   = rpt_key_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    rpt_evt_c   = '0;
    dir_press_c = 1'b0;
    dir_idx_c   = '0;
    for (int i = int'(CMD_RIGHT); i >= 0; i--) begin
      if (press_c[i]) begin
        dir_press_c = 1'b1;
        dir_idx_c   = CODE_W'(i);
      end
    end
    if (dir_press_c) begin
      state_d   = RPT_DELAY;
      rpt_key_d = dir_idx_c;
      cnt_d     = '0;
    end else if (state_q != RPT_IDLE && key_db[rpt_key_q]) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          cnt_d = '0;
        end
        RPT_DELAY: begin
          if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            rpt_evt_c[rpt_key_q] = 1'b1;
            cnt_d                = '0;
            state_d              = RPT_REPEAT;
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            rpt_evt_c[rpt_key_q] = 1'b1;
            cnt_d                = '0;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q   <= RPT_IDLE;
      rpt_key_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rpt_key_q <= rpt_key_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  // No auto-repeat: only fresh presses generate events.
  always_comb begin
    rpt_evt_c = '0;
  end
`endif

  // Pending set: lowest index drains into the FIFO, new events merge into held bits.
  always_comb begin
    sel_c     = '0;
    sel_any_c = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_any_c = 1'b1;
        sel_c     = CODE_W'(i);
      end
    end
    pop_c           = fifo_valid_c & cmd_ready;
    push_c          = sel_any_c & (~fifo_full_c | pop_c);
    push_cmd_c.rpt  = pending_rpt_q[sel_c];
    push_cmd_c.code = sel_c;
    pending_d       = pending_q;
    pending_rpt_d   = pending_rpt_q;
    if (push_c) begin
      pending_d[sel_c] = 1'b0;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (press_c[i]) begin
        pending_d[i]     = 1'b1;
        pending_rpt_d[i] = 1'b0;
      end else if (rpt_evt_c[i] && !pending_d[i]) begin
        pending_d[i]     = 1'b1;
        pending_rpt_d[i] = 1'b1;
      end
    end
  end

  // Pending registers.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      pending_q     <= '0;
      pending_rpt_q <= '0;
    end else begin
      pending_q     <= pending_d;
      pending_rpt_q <= pending_rpt_d;
    end
  end

  cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(cmd_t))
  ) u_fifo (
    .clk       (pixel_clk),
    .rst       (sys_rst),
    .push      (push_c),
    .push_data (push_cmd_c),
    .pop       (pop_c),
    .full_c    (fifo_full_c),
    .valid_c   (fifo_valid_c),
    .head_c    (head_c)
  );

  // Head of FIFO drives the command port; rpt stays 0 when repeat is not built.
  always_comb begin
    cmd_valid = fifo_valid_c;
    cmd_code  = head_c.code;
    cmd_rpt   = head_c.rpt;
  end

endmodule

// File: tb/tb_key_cmd_encoder.sv
// Directed bench for key_cmd_encoder with REPEAT_DELAY=8, REPEAT_PERIOD=4, FIFO_DEPTH=4.
module tb_key_cmd_encoder;

`ifdef KEY_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic       pixel_clk = 1'b0;
  logic       sys_rst;
  logic [5:0] key_db;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic       cmd_rpt;
  int         total = 0;
  int         bad   = 0;
  logic       exp_v;

  always #5 pixel_clk = ~pixel_clk;

  key_cmd_encoder #(
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .FIFO_DEPTH    (4)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .key_db    (key_db),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_rpt   (cmd_rpt)
  );

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    key_db    = 6'b111111;
    cmd_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 8'(cmd_valid), 8'd0);
    chk("rst_code",  8'(cmd_code),  8'd0);
    chk("rst_rpt",   8'(cmd_rpt),   8'd0);
    sys_rst = 1'b0;
    tick();
    chk("idle_valid", 8'(cmd_valid), 8'd0);

    // single press of key 2
    key_db = 6'b111011;
    tick();
    chk("p1_early", 8'(cmd_valid), 8'd0);
    tick();
    chk("p1_valid", 8'(cmd_valid), 8'd1);
    chk("p1_code",  8'(cmd_code),  8'd2);
    chk("p1_rpt",   8'(cmd_rpt),   8'd0);
    tick();
    chk("p1_once", 8'(cmd_valid), 8'd0);
    key_db = 6'b111111;
    tick();
    tick();

    // simultaneous press of keys 0, 2, 4
    key_db = 6'b101010;
    tick();
    key_db = 6'b111111;
    chk("sim_early", 8'(cmd_valid), 8'd0);
    tick();
    chk("sim_v0", 8'(cmd_valid), 8'd1);
    chk("sim_c0", 8'(cmd_code),  8'd0);
    chk("sim_r0", 8'(cmd_rpt),   8'd0);
    tick();
    chk("sim_v2", 8'(cmd_valid), 8'd1);
    chk("sim_c2", 8'(cmd_code),  8'd2);
    chk("sim_r2", 8'(cmd_rpt),   8'd0);
    tick();
    chk("sim_v4", 8'(cmd_valid), 8'd1);
    chk("sim_c4", 8'(cmd_code),  8'd4);
    chk("sim_r4", 8'(cmd_rpt),   8'd0);
    tick();
    chk("sim_done", 8'(cmd_valid), 8'd0);

    // backpressure: six presses into a 4-entry FIFO
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_db = ~(6'd1 << i);
      tick();
    end
    key_db = 6'b111111;
    chk("bp_valid", 8'(cmd_valid), 8'd1);
    chk("bp_code",  8'(cmd_code),  8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_v", 8'(cmd_valid), 8'd1);
      chk("bp_hold_c", 8'(cmd_code),  8'd0);
    end
    cmd_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      chk("bp_drain_v", 8'(cmd_valid), 8'd1);
      chk("bp_drain_c", 8'(cmd_code),  8'(k));
      chk("bp_drain_r", 8'(cmd_rpt),   8'd0);
    end
    tick();
    chk("bp_empty", 8'(cmd_valid), 8'd0);

    // key 1 held for 20 cycles
    key_db = 6'b111101;
    for (int k = 0; k < 26; k++) begin
      tick();
      exp_v = (k == 1) || (RPT_EN && (k == 9 || k == 13 || k == 17));
      chk("ar_valid", 8'(cmd_valid), 8'(exp_v));
      if (exp_v) begin
        chk("ar_code", 8'(cmd_code), 8'd1);
        chk("ar_rpt",  8'(cmd_rpt),  8'(k != 1));
      end
      if (k == 19) begin
        key_db = 6'b111111;
      end
    end

    // reset with three commands queued and key 3 held through it
    cmd_ready = 1'b0;
    key_db = 6'b111110;
    tick();
    key_db = 6'b111101;
    tick();
    key_db = 6'b111011;
    tick();
    key_db = 6'b110111;
    tick();
    chk("rm_queued_v", 8'(cmd_valid), 8'd1);
    chk("rm_queued_c", 8'(cmd_code),  8'd0);
    sys_rst = 1'b1;
    tick();
    chk("rm_rst_v", 8'(cmd_valid), 8'd0);
    chk("rm_rst_c", 8'(cmd_code),  8'd0);
    chk("rm_rst_r", 8'(cmd_rpt),   8'd0);
    sys_rst   = 1'b0;
    cmd_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("rm_held_v", 8'(cmd_valid), 8'd0);
    end
    key_db = 6'b111111;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
